// File: rtl/dma_seq_pkg.sv
// Shared types and constants for the DMA task sequencer.
//   - One-hot init task codes driven on slaveInit.
//   - Task order table (step index -> one-hot task) and channel-enable helpers.
//   - Status codes reported to bank1 and the sequencer FSM encoding.
package dma_seq_pkg;

    localparam int unsigned TASK_CNT = 6;
    localparam int unsigned STEP_CNT = 6;

    typedef logic [TASK_CNT-1:0] task_vec_t;
    typedef logic [2:0]          step_t;
    typedef logic [1:0]          status_t;

    localparam task_vec_t TASK_SRC_CTRL = 6'b000001;
    localparam task_vec_t TASK_SRC_ADDR = 6'b000010;
    localparam task_vec_t TASK_SRC_SIZE = 6'b000100;
    localparam task_vec_t TASK_DES_CTRL = 6'b001000;
    localparam task_vec_t TASK_DES_ADDR = 6'b010000;
    localparam task_vec_t TASK_DES_SIZE = 6'b100000;

    localparam status_t ST_IDLE = 2'b00;
    localparam status_t ST_BUSY = 2'b01;
    localparam status_t ST_DONE = 2'b10;
    localparam status_t ST_ERR  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWait,
        StGap,
        StDone
    } seq_state_e;

    typedef struct packed {
        logic  found;
        step_t step;
    } step_pick_t;

    // S2MM is armed before MM2S; each channel's size write goes last because it
    // kicks the channel off.
    function automatic task_vec_t task_at(input step_t step);
        task_vec_t t;
        case (step)
            3'd0:    t = TASK_DES_CTRL;
            3'd1:    t = TASK_DES_ADDR;
            3'd2:    t = TASK_DES_SIZE;
            3'd3:    t = TASK_SRC_CTRL;
            3'd4:    t = TASK_SRC_ADDR;
            3'd5:    t = TASK_SRC_SIZE;
            default: t = '0;
        endcase
        return t;
    endfunction

    // Steps 0..2 are des-channel tasks (mode[1]), steps 3..5 src-channel (mode[0]).
    function automatic logic step_enabled(input step_t step, input logic [1:0] mode);
        return (step < 3'd3) ? mode[1] : mode[0];
    endfunction

    // First enabled step at or after 'from'; found=0 when nothing is left.
    function automatic step_pick_t find_step(input step_t from, input logic [1:0] mode);
        step_pick_t pick;
        pick = '0;
        for (int unsigned i = 0; i < STEP_CNT; i++) begin
            if (!pick.found && step_t'(i) >= from && step_enabled(step_t'(i), mode)) begin
                pick.found = 1'b1;
                pick.step  = step_t'(i);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/dma_seq_timer.sv
// Cycle counters for the DMA task sequencer.
//   clk, reset   clock, synchronous active-low reset
//   prof_clear   zero the profile counter (transfer accept)
//   prof_en      count this cycle (sequencer busy)
//   profile      saturating cycle count
// With DMA_SEQ_TIMEOUT_EN defined a per-task watchdog is added:
//   wd_en        sequencer is waiting on a task; counter is zero whenever low
//   wd_timeout   this is the TIMEOUT_CYCLES-th consecutive waiting cycle
module dma_seq_timer #(
    parameter int unsigned PROFILE_WIDTH = 32
`ifdef DMA_SEQ_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     prof_clear,
    input  logic                     prof_en,
`ifdef DMA_SEQ_TIMEOUT_EN
    input  logic                     wd_en,
    output logic                     wd_timeout,
`endif
    output logic [PROFILE_WIDTH-1:0] profile
);

    logic [PROFILE_WIDTH-1:0] prof_q, prof_d;

    always_comb begin
        prof_d = prof_q;
        if (prof_clear) begin
            prof_d = '0;
        end else if (prof_en && prof_q != '1) begin
            prof_d = prof_q + PROFILE_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prof_q <= '0;
        end else begin
            prof_q <= prof_d;
        end
    end

    assign profile = prof_q;

`ifdef DMA_SEQ_TIMEOUT_EN
    localparam int unsigned WdWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WdWidth-1:0] wd_q, wd_d;

    // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
    always_comb begin
        wd_d = '0;
        if (wd_en) begin
            wd_d = wd_q + WdWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign wd_timeout = wd_en && (wd_q == WdWidth'(TIMEOUT_CYCLES - 1));
`endif

endmodule

// File: rtl/dma_task_sequencer.sv
// Sequences one DMA slot transfer through the AXI-Lite write master.
//   clk, reset                 clock, synchronous active-low reset
//   seq_start / seq_ready      start request, accepted only while idle
//   seq_mode                   [0] run src (MM2S) tasks, [1] run des (S2MM) tasks
//   in_src_* / in_des_*        slot addresses and sizes, latched at accept
//   out_src_* / out_des_*      latched slot, stable for the whole transfer
//   slaveInit / slaveFinInit   one-hot task request / completion pulse
//   seq_done, seq_status       completion pulse; 00 idle, 01 busy, 10 done, 11 error
//   seq_profile                saturating cycles from LOAD through DONE
// Optional macro DMA_SEQ_TIMEOUT_EN adds a per-task watchdog (TIMEOUT_CYCLES).
module dma_task_sequencer
    import dma_seq_pkg::*;
#(
    parameter int unsigned GLOB_ADDR_WIDTH      = 32,
    parameter int unsigned BANK1_DST_ADDR_WIDTH = 32,
    parameter int unsigned BANK1_DST_SIZE_WIDTH = 26,
    parameter int unsigned BANK1_STATUS_WIDTH   = 2,
    parameter int unsigned BANK1_PROFILE_WIDTH  = 32,
    parameter int unsigned DMA_INIT_TASK_CNT    = 6
`ifdef DMA_SEQ_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            seq_start,
    output logic                            seq_ready,
    input  logic [1:0]                      seq_mode,
    input  logic [BANK1_DST_ADDR_WIDTH-1:0] in_src_addr,
    input  logic [BANK1_DST_SIZE_WIDTH-1:0] in_src_size,
    input  logic [BANK1_DST_ADDR_WIDTH-1:0] in_des_addr,
    input  logic [BANK1_DST_SIZE_WIDTH-1:0] in_des_size,
    output logic [BANK1_DST_ADDR_WIDTH-1:0] out_src_addr,
    output logic [BANK1_DST_SIZE_WIDTH-1:0] out_src_size,
    output logic [BANK1_DST_ADDR_WIDTH-1:0] out_des_addr,
    output logic [BANK1_DST_SIZE_WIDTH-1:0] out_des_size,
    output logic [DMA_INIT_TASK_CNT-1:0]    slaveInit,
    input  logic [DMA_INIT_TASK_CNT-1:0]    slaveFinInit,
    output logic                            seq_done,
    output logic [BANK1_STATUS_WIDTH-1:0]   seq_status,
    output logic [BANK1_PROFILE_WIDTH-1:0]  seq_profile
);

    if (BANK1_DST_ADDR_WIDTH > GLOB_ADDR_WIDTH) begin : g_bad_addr_width
        $error("slot address wider than the AXI address bus");
    end
    if (DMA_INIT_TASK_CNT != TASK_CNT || BANK1_STATUS_WIDTH != 2) begin : g_bad_cfg
        $error("task vector must be 6 bits and status 2 bits");
    end

    seq_state_e                   state_q, state_d;
    step_t                        step_q, step_d;
    logic [1:0]                   mode_q;
    logic [DMA_INIT_TASK_CNT-1:0] slave_init_q, slave_init_d;
    status_t                      status_q, status_d;
    step_t                        search_from;
    step_pick_t                   pick;
    logic                         accept;
`ifdef DMA_SEQ_TIMEOUT_EN
    logic                         wd_timeout;
`endif

    assign seq_ready = (state_q == StIdle);
    assign accept    = seq_start && seq_ready;

    // From LOAD search starts at step 0; from GAP just past the task that finished.
    assign search_from = (state_q == StGap) ? step_q + 3'd1 : 3'd0;
    assign pick        = find_step(search_from, mode_q);

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        slave_init_d = slave_init_q;
        status_d     = status_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StLoad;
                    status_d = ST_BUSY;
                end
            end
            StLoad, StGap: begin
                if (pick.found) begin
                    state_d      = StWait;
                    step_d       = pick.step;
                    slave_init_d = DMA_INIT_TASK_CNT'(task_at(pick.step));
                end else begin
                    state_d  = StDone;
                    status_d = ST_DONE;
                end
            end
            StWait: begin
                if (slaveFinInit == slave_init_q) begin
                    state_d      = StGap;
                    slave_init_d = '0;
                end else if (|slaveFinInit) begin
                    state_d      = StDone;
                    slave_init_d = '0;
                    status_d     = ST_ERR;
                end
`ifdef DMA_SEQ_TIMEOUT_EN
                else if (wd_timeout) begin
                    state_d      = StDone;
                    slave_init_d = '0;
                    status_d     = ST_ERR;
                end
`endif
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d      = StIdle;
                slave_init_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            step_q       <= '0;
            mode_q       <= '0;
            slave_init_q <= '0;
            status_q     <= ST_IDLE;
            out_src_addr <= '0;
            out_src_size <= '0;
            out_des_addr <= '0;
            out_des_size <= '0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            slave_init_q <= slave_init_d;
            status_q     <= status_d;
            if (accept) begin
                mode_q       <= seq_mode;
                out_src_addr <= in_src_addr;
                out_src_size <= in_src_size;
                out_des_addr <= in_des_addr;
                out_des_size <= in_des_size;
            end
        end
    end

    dma_seq_timer #(
        .PROFILE_WIDTH  (BANK1_PROFILE_WIDTH)
`ifdef DMA_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .prof_clear (accept),
        .prof_en    (state_q != StIdle),
`ifdef DMA_SEQ_TIMEOUT_EN
        .wd_en      (state_q == StWait),
        .wd_timeout (wd_timeout),
`endif
        .profile    (seq_profile)
    );

    assign slaveInit  = slave_init_q;
    assign seq_done   = (state_q == StDone);
    assign seq_status = BANK1_STATUS_WIDTH'(status_q);

endmodule

// File: tb/tb_dma_task_sequencer.sv
module tb_dma_task_sequencer;

    localparam int unsigned AW = 32;
    localparam int unsigned SW = 26;
`ifdef DMA_SEQ_TIMEOUT_EN
    localparam int unsigned TO_CYCLES = 16;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          seq_start;
    logic          seq_ready;
    logic [1:0]    seq_mode;
    logic [AW-1:0] in_src_addr, in_des_addr, out_src_addr, out_des_addr;
    logic [SW-1:0] in_src_size, in_des_size, out_src_size, out_des_size;
    logic [5:0]    slaveInit, slaveFinInit;
    logic          seq_done;
    logic [1:0]    seq_status;
    logic [31:0]   seq_profile;

    always #5 clk = ~clk;

    dma_task_sequencer #(
        .GLOB_ADDR_WIDTH      (32),
        .BANK1_DST_ADDR_WIDTH (AW),
        .BANK1_DST_SIZE_WIDTH (SW),
        .BANK1_STATUS_WIDTH   (2),
        .BANK1_PROFILE_WIDTH  (32),
        .DMA_INIT_TASK_CNT    (6)
`ifdef DMA_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYCLES     (TO_CYCLES)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .seq_start    (seq_start),
        .seq_ready    (seq_ready),
        .seq_mode     (seq_mode),
        .in_src_addr  (in_src_addr),
        .in_src_size  (in_src_size),
        .in_des_addr  (in_des_addr),
        .in_des_size  (in_des_size),
        .out_src_addr (out_src_addr),
        .out_src_size (out_src_size),
        .out_des_addr (out_des_addr),
        .out_des_size (out_des_size),
        .slaveInit    (slaveInit),
        .slaveFinInit (slaveFinInit),
        .seq_done     (seq_done),
        .seq_status   (seq_status),
        .seq_profile  (seq_profile)
    );

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] exp_sa, exp_da;
    logic [SW-1:0] exp_ss, exp_ds;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic new_slot();
        exp_sa = $urandom();
        exp_da = $urandom();
        exp_ss = SW'($urandom());
        exp_ds = SW'($urandom());
        in_src_addr = exp_sa;
        in_des_addr = exp_da;
        in_src_size = exp_ss;
        in_des_size = exp_ds;
    endtask

    task automatic check_slot(input string name);
        check($sformatf("%s out_src_addr", name), 64'(out_src_addr), 64'(exp_sa));
        check($sformatf("%s out_src_size", name), 64'(out_src_size), 64'(exp_ss));
        check($sformatf("%s out_des_addr", name), 64'(out_des_addr), 64'(exp_da));
        check($sformatf("%s out_des_size", name), 64'(out_des_size), 64'(exp_ds));
    endtask

    // One transfer against a master model that acks each task after a random
    // (or fixed) number of request cycles. Expected task list, profile and
    // status come from the channel/order rules, not from the DUT.
    task automatic run_slot(input string name, input logic [1:0] mode, input int fixed_delay,
                            input int wrong_idx, input logic [5:0] wrong_val,
                            input bit repulse, input bit start_in_done,
                            input logic [5:0] reset_on, output bit aborted);
        int         order [6] = '{3, 4, 5, 0, 1, 2};
        logic [5:0] exp_q[$];
        logic [5:0] got_q[$];
        int         delays[$];
        int         n_run, exp_prof, done_iter, post, cur_idx, held, zero_run;
        int         gap_bad, stable_bad, done_cnt, after_bad;
        logic [5:0] si, prev_si;
        logic [1:0] done_status, exp_status;

        aborted = 1'b0;
        foreach (order[i]) begin
            if ((order[i] >= 3) ? mode[1] : mode[0]) exp_q.push_back(6'(1 << order[i]));
        end
        foreach (exp_q[i]) delays.push_back(fixed_delay > 0 ? fixed_delay : int'($urandom_range(6, 1)));
        n_run    = (wrong_idx >= 0) ? wrong_idx + 1 : exp_q.size();
        // LOAD + DONE, plus per task its wait cycles and the gap (none after an error).
        exp_prof = 2;
        for (int i = 0; i < n_run; i++) exp_prof += delays[i] + ((i == wrong_idx) ? 0 : 1);
        exp_status = (wrong_idx >= 0) ? 2'b11 : 2'b10;

        @(negedge clk);
        new_slot();
        seq_mode  = mode;
        seq_start = 1'b1;
        @(negedge clk);
        seq_start = 1'b0;

        done_iter = -1; post = 0; cur_idx = -1; held = 0; zero_run = 0;
        gap_bad = 0; stable_bad = 0; done_cnt = 0; after_bad = 0;
        prev_si = '0; done_status = '0;
        for (int iter = 0; iter < 400; iter++) begin
            si           = slaveInit;
            slaveFinInit = '0;
            seq_start    = 1'b0;
            if (repulse && iter == 3) begin
                seq_start   = 1'b1;
                seq_mode    = ~mode;
                in_src_addr = ~exp_sa;
                in_src_size = ~exp_ss;
                in_des_addr = ~exp_da;
                in_des_size = ~exp_ds;
            end
            if (si != '0) begin
                if (prev_si == '0) begin
                    cur_idx++;
                    got_q.push_back(si);
                    if (cur_idx > 0 && zero_run != 1) gap_bad++;
                    held = 0;
                    if (reset_on != '0 && si == reset_on) begin
                        reset   = 1'b0;
                        aborted = 1'b1;
                        break;
                    end
                end else if (si != prev_si) begin
                    stable_bad++;
                end
                held++;
                if (done_iter < 0 && cur_idx < delays.size() && held == delays[cur_idx])
                    slaveFinInit = (cur_idx == wrong_idx) ? wrong_val : si;
                zero_run = 0;
                if (done_iter >= 0) after_bad++;
            end else begin
                zero_run++;
            end
            if (seq_done) begin
                done_cnt++;
                done_status = seq_status;
                if (done_iter < 0) done_iter = iter;
                if (start_in_done) seq_start = 1'b1;
            end
            if (done_iter >= 0 && iter > done_iter) begin
                post++;
                if (post == 3) break;
            end
            prev_si = si;
            @(negedge clk);
        end
        seq_start    = 1'b0;
        slaveFinInit = '0;
        if (!aborted) begin
            check($sformatf("%s done pulses", name), 64'(done_cnt), 64'(1));
            check($sformatf("%s done cycle", name), 64'(done_iter), 64'(exp_prof - 1));
            check($sformatf("%s status at done", name), 64'(done_status), 64'(exp_status));
            check($sformatf("%s status held", name), 64'(seq_status), 64'(exp_status));
            check($sformatf("%s ready", name), 64'(seq_ready), 64'(1));
            check($sformatf("%s profile", name), 64'(seq_profile), 64'(exp_prof));
            check($sformatf("%s task count", name), 64'(got_q.size()), 64'(n_run));
            for (int i = 0; i < n_run && i < got_q.size(); i++)
                check($sformatf("%s task%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
            check($sformatf("%s gap violations", name), 64'(gap_bad), 64'(0));
            check($sformatf("%s unstable request", name), 64'(stable_bad), 64'(0));
            check($sformatf("%s request after done", name), 64'(after_bad), 64'(0));
            check_slot(name);
        end
    endtask

    initial begin
        bit         aborted;
        int         wait_cnt;
        bit         done_seen;
        logic [1:0] mode;

        reset        = 1'b0;
        seq_start    = 1'b0;
        seq_mode     = 2'b11;
        slaveFinInit = '0;
        new_slot();
        repeat (3) @(negedge clk);
        check("reset ready", 64'(seq_ready), 64'(1));
        check("reset slaveInit", 64'(slaveInit), 64'(0));
        check("reset done", 64'(seq_done), 64'(0));
        check("reset status", 64'(seq_status), 64'(0));
        check("reset profile", 64'(seq_profile), 64'(0));
        check("reset out_src_addr", 64'(out_src_addr), 64'(0));
        check("reset out_des_size", 64'(out_des_size), 64'(0));
        reset = 1'b1;

        run_slot("m11 fixed4", 2'b11, 4, -1, '0, 1'b0, 1'b0, '0, aborted);
        run_slot("m01", 2'b01, 0, -1, '0, 1'b0, 1'b0, '0, aborted);
        run_slot("m10", 2'b10, 0, -1, '0, 1'b0, 1'b0, '0, aborted);
        run_slot("m00 start in done", 2'b00, 0, -1, '0, 1'b0, 1'b1, '0, aborted);
        run_slot("wrong fin", 2'b11, 0, 1, 6'h02, 1'b0, 1'b0, '0, aborted);
        run_slot("repulse busy", 2'b11, 0, -1, '0, 1'b1, 1'b0, '0, aborted);
        for (int k = 0; k < 4; k++) begin
            mode = 2'($urandom());
            run_slot($sformatf("rand%0d", k), mode, 0, -1, '0, 1'b0, 1'b0, '0, aborted);
        end

        // Reset while task 20 (des size) is being waited on.
        run_slot("reset mid", 2'b11, 0, -1, '0, 1'b0, 1'b0, 6'h20, aborted);
        check("reset mid aborted", 64'(aborted), 64'(1));
        @(negedge clk);
        check("reset mid slaveInit", 64'(slaveInit), 64'(0));
        check("reset mid status", 64'(seq_status), 64'(0));
        check("reset mid ready", 64'(seq_ready), 64'(1));
        check("reset mid profile", 64'(seq_profile), 64'(0));
        reset = 1'b1;
        run_slot("after reset", 2'b11, 0, -1, '0, 1'b0, 1'b0, '0, aborted);

        // Master never acks.
        @(negedge clk);
        new_slot();
        seq_mode  = 2'b01;
        seq_start = 1'b1;
        @(negedge clk);
        seq_start = 1'b0;
        wait_cnt  = 0;
        done_seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (slaveInit != '0) wait_cnt++;
            if (seq_done) begin
                done_seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
`ifdef DMA_SEQ_TIMEOUT_EN
        check("timeout done", 64'(done_seen), 64'(1));
        check("timeout wait cycles", 64'(wait_cnt), 64'(TO_CYCLES));
        check("timeout status", 64'(seq_status), 64'(2'b11));
        @(negedge clk);
        check("timeout slaveInit", 64'(slaveInit), 64'(0));
`else
        check("no ack done", 64'(done_seen), 64'(0));
        check("no ack status", 64'(seq_status), 64'(2'b01));
        check("no ack slaveInit", 64'(slaveInit), 64'(6'h01));
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("no ack reset slaveInit", 64'(slaveInit), 64'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
